// File: rtl/regfile_write_queue.sv
// Write-back queue feeding the regfile write port: a small FIFO with an empty-queue
// bypass, a registered write strobe/index/data, and per-read-port in-flight hazard flags.
module regfile_write_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_reg,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  ctrl_writeEnable,
  output logic [ADDR_WIDTH-1:0] ctrl_writeReg,
  output logic [DATA_WIDTH-1:0] data_writeReg,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
  output logic                  pendingA,
  output logic                  pendingB,
  output logic [CNT_W-1:0]      count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_WIDTH-1:0] reg_mem_q  [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] wreg_q, wreg_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic accept, pop, enq;
  logic [PTR_W-1:0] idx;
  logic hit_a, hit_b;

  assign in_ready = (count_q != CNT_W'(DEPTH));
  // Writes to r0 complete the handshake but are discarded here.
  assign accept   = in_valid && in_ready && (in_reg != '0);
  assign pop      = (count_q != '0);
  // With an empty queue the accepted write goes straight to the output stage.
  assign enq      = accept && pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(enq);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(enq) - CNT_W'(pop);
    we_d     = 1'b0;
    wreg_d   = wreg_q;
    wdata_d  = wdata_q;
    if (pop) begin
      we_d    = 1'b1;
      wreg_d  = reg_mem_q[rd_ptr_q];
      wdata_d = data_mem_q[rd_ptr_q];
    end else if (accept) begin
      we_d    = 1'b1;
      wreg_d  = in_reg;
      wdata_d = in_data;
    end
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
    end
  end

  // Storage is qualified by count, so it needs no reset.
  always_ff @(posedge clock) begin
    if (enq) begin
      reg_mem_q[wr_ptr_q]  <= in_reg;
      data_mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Hazard search over the live window [rd_ptr, rd_ptr+count) plus the output stage.
  always_comb begin
    hit_a = we_q && (wreg_q == ctrl_readRegA);
    hit_b = we_q && (wreg_q == ctrl_readRegB);
    idx   = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if (reg_mem_q[idx] == ctrl_readRegA) hit_a = 1'b1;
        if (reg_mem_q[idx] == ctrl_readRegB) hit_b = 1'b1;
      end
    end
  end

  assign pendingA         = (ctrl_readRegA != '0) && hit_a;
  assign pendingB         = (ctrl_readRegB != '0) && hit_b;
  assign count            = count_q;
  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;

endmodule

// File: tb/tb_regfile_write_queue.sv
// Bench for regfile_write_queue: directed scenarios followed by random traffic, all
// compared each cycle against a queue-based reference model of the write-back rules.
module tb_regfile_write_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;

  logic          clock = 1'b0;
  logic          ctrl_reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_reg;
  logic [DW-1:0] in_data;
  logic          ctrl_writeEnable;
  logic [AW-1:0] ctrl_writeReg;
  logic [DW-1:0] data_writeReg;
  logic [AW-1:0] ctrl_readRegA;
  logic [AW-1:0] ctrl_readRegB;
  logic          pendingA;
  logic          pendingB;
  logic [2:0]    count;

  regfile_write_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .pendingA(pendingA), .pendingB(pendingB), .count(count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } wb_t;

  // Reference model: pending writes as a plain queue plus the write-port contents.
  wb_t           m_q[$];
  logic          m_we;
  logic [AW-1:0] m_reg;
  logic [DW-1:0] m_data;
  wb_t           issued[$];

  int total = 0;
  int bad   = 0;
  int max_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_pending(input logic [AW-1:0] x);
    if (x == 0) return 1'b0;
    if (m_we && m_reg == x) return 1'b1;
    foreach (m_q[i]) if (m_q[i].r == x) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle: drive inputs at the falling edge, check everything the DUT
  // presents in that cycle, then advance the model to what the next edge should produce.
  task automatic cycle(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rb, input logic rst);
    logic acc;
    @(negedge clock);
    in_valid = v; in_reg = r; in_data = d;
    ctrl_readRegA = ra; ctrl_readRegB = rb; ctrl_reset = rst;
    #1;
    check("count",    64'(count),            64'(m_q.size()));
    check("in_ready", 64'(in_ready),         64'(m_q.size() != DEPTH));
    check("we",       64'(ctrl_writeEnable), 64'(m_we));
    check("wreg",     64'(ctrl_writeReg),    64'(m_reg));
    check("wdata",    64'(data_writeReg),    64'(m_data));
    check("pendingA", 64'(pendingA),         64'(model_pending(ra)));
    check("pendingB", 64'(pendingB),         64'(model_pending(rb)));
    if (int'(count) > max_cnt) max_cnt = int'(count);
    acc = v && (m_q.size() != DEPTH) && (r != 0);
    if (rst) begin
      m_q.delete(); m_we = 1'b0; m_reg = '0; m_data = '0;
    end else if (m_q.size() > 0) begin
      wb_t h;
      h = m_q.pop_front();
      m_we = 1'b1; m_reg = h.r; m_data = h.d;
      if (acc) m_q.push_back('{r: r, d: d});
    end else if (acc) begin
      m_we = 1'b1; m_reg = r; m_data = d;
    end else begin
      m_we = 1'b0;
    end
    if (!rst && m_we) issued.push_back('{r: m_reg, d: m_data});
  endtask

  initial begin
    in_valid = 0; in_reg = '0; in_data = '0;
    ctrl_readRegA = '0; ctrl_readRegB = '0; ctrl_reset = 1'b1;
    @(posedge clock);
    m_q.delete(); m_we = 1'b0; m_reg = '0; m_data = '0;
    cycle(0, 0, 0, 0, 0, 1);

    // T1: traffic then a one-cycle reset; nothing in flight afterwards.
    cycle(1, 1, 32'h11, 1, 2, 0);
    cycle(1, 2, 32'h22, 1, 2, 0);
    cycle(1, 3, 32'h33, 2, 3, 0);
    cycle(0, 0, 0, 3, 3, 1);
    issued.delete();
    for (int i = 0; i < 32; i++) cycle(0, 0, 0, AW'(i), AW'(31 - i), 0);
    check("t1_no_writes", 64'(issued.size()), 64'd0);

    // T2: bypass into an empty queue.
    cycle(1, 5, 32'hDEADBEEF, 5, 0, 0);
    cycle(0, 0, 0, 5, 0, 0);
    check("t2_we",   64'(ctrl_writeEnable), 64'd1);
    check("t2_reg",  64'(ctrl_writeReg),    64'd5);
    check("t2_data", 64'(data_writeReg),    64'hDEADBEEF);
    check("t2_pend", 64'(pendingA),         64'd1);
    cycle(0, 0, 0, 5, 0, 0);
    check("t2_pend_clear", 64'(pendingA), 64'd0);

    // T3: r1..r6 back-to-back; writes emerge in order with no loss.
    issued.delete();
    for (int i = 1; i <= 6; i++) cycle(1, AW'(i), DW'(i * 16), AW'(i), AW'(i - 1), 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, AW'(i), 0, 0);
    check("t3_n", 64'(issued.size()), 64'd6);
    for (int i = 0; i < issued.size(); i++) check("t3_order", 64'(issued[i].r), 64'(i + 1));

    // T4: r0 is accepted but dropped.
    issued.delete();
    cycle(1, 0, 32'h1234, 0, 7, 0);
    cycle(1, 7, 32'h55, 0, 7, 0);
    cycle(0, 0, 0, 0, 7, 0);
    cycle(0, 0, 0, 0, 7, 0);
    check("t4_n",    64'(issued.size()), 64'd1);
    check("t4_reg",  64'(issued[0].r),   64'd7);
    check("t4_data", 64'(issued[0].d),   64'h55);

    // T5: ten pushes with random gaps.
    issued.delete();
    for (int i = 0; i < 10; i++) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) cycle(0, 0, 0, AW'(i + 8), 0, 0);
      cycle(1, AW'(i + 8), $urandom, AW'(i + 8), AW'(i + 7), 0);
    end
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0, 0);
    check("t5_n", 64'(issued.size()), 64'd10);
    for (int i = 0; i < issued.size(); i++) check("t5_order", 64'(issued[i].r), 64'(i + 8));

    // T6: duplicate destinations issue in order.
    issued.delete();
    cycle(1, 3, 32'd1, 0, 3, 0);
    cycle(1, 3, 32'd2, 0, 3, 0);
    check("t6_pend", 64'(pendingB), 64'd1);
    cycle(0, 0, 0, 0, 3, 0);
    check("t6_pend2", 64'(pendingB), 64'd1);
    cycle(0, 0, 0, 0, 3, 0);
    check("t6_pend_clear", 64'(pendingB), 64'd0);
    check("t6_n",     64'(issued.size()), 64'd2);
    check("t6_first", 64'(issued[0].d),   64'd1);
    check("t6_last",  64'(issued[1].d),   64'd2);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, AW'($urandom_range(0, 7)), $urandom,
            AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), ($urandom % 50) == 0);
    end
    check("max_count", 64'(max_cnt <= DEPTH), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
